cpu_fifo_arbiter: RTL and testbench
===================================

# cpu_fifo_arbiter

Round-robin arbiter that shares one CPU FIFO write port among `requesters` producers, such as the fetch, load/store and debug paths that push into a common queue. Each producer drives a valid/full handshake identical to the FIFO's own. The arbiter selects one producer at a time and forwards its beats through a single registered output stage into the FIFO's `input_data`/`input_valid`/`input_full` port.

## Interface
- `width`, 32, data beat width
- `requesters`, 4, number of producers (≥1)
- `burst`, 4, max consecutive beats per grant (used only with `CPU_ARB_BURST_EN`; ≥1)

- `clock`  in  1  single clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `req_data`  in  requesters*width  packed; slice i = producer i
- `req_valid`  in  requesters  producer i presents a beat
- `req_full`  out  requesters  producer i must hold data/valid (beat not taken)
- `output_data`  out  width  registered beat to FIFO `input_data`
- `output_valid`  out  1  registered, to FIFO `input_valid`
- `output_full`  in  1  from FIFO `input_full`; downstream cannot take a beat
- `grant_id`  out  idxW  current grant index; idxW = max(1, $clog2(requesters))
- `grant_active`  out  1  high in GRANT

## Operation
- States: IDLE (no grant) and GRANT (grant held on `grant_id`). A `last` pointer records the most recently granted index.
- Output slot free: `!output_valid || !output_full`.
- `req_full[i] = !(state==GRANT && grant_id==i && slot free)`. This is combinational from state and `output_full` only, never from `req_valid`.
- Beat accept at edge: `req_valid[g] && !req_full[g]` → `output_data <= req_data[g]`, `output_valid <= 1`.
- Output drain at edge: `output_valid && !output_full` with no accept in the same cycle → `output_valid <= 0`. With `output_full=1`, output register holds data and valid unchanged.
- Pick: lowest index at or after `last+1` (mod requesters) with `req_valid` set. Wrap-around is included, so `last` itself is checked last.
- IDLE → GRANT when any `req_valid` is set. Grant goes to the pick; `last <=` pick.
- GRANT release conditions:
  - the granted producer has `req_valid=0` and the slot is free; or
  - the beat limit is reached (see Configuration).
- On release, re-pick in the same edge from the current `req_valid` vector:
  - any valid → stay GRANT with the new index and update `last`;
  - none valid → IDLE.
- GRANT with the slot not free: no release, no accept, grant holds.
- `requesters=1`: the pick is always 0 and round-robin degenerates to a pass-through with a register.

## Timing
- Reset values: `output_valid=0`, `output_data=0`, `req_full` all 1, `grant_id=0`, `grant_active=0`, state IDLE, `last=requesters-1` (first pick favours index 0), beat counter 0.
- Reset mid-operation discards any beat held in the output register. A producer whose beat was already accepted does not re-send it.
- Arbitration latency: 1 cycle from IDLE (valid seen at edge t, grant effective in cycle t+1, first accept at edge t+1).
- Data latency: accept at edge t → `output_valid`/`output_data` visible in cycle t+1.
- Back-to-back grant hand-off: no bubble between producers.
- Steady state: one beat per cycle while `output_full=0`.

## Configuration
- `CPU_ARB_BURST_EN` defined:
  - a beat counter (width $clog2(burst+1)) counts accepts under the current grant;
  - release when the count reaches `burst` or when the granted valid drops;
  - the counter clears on every grant change.
- Undefined: the grant is released after every accepted beat, so producers interleave strictly round-robin beat by beat. Release also occurs when the granted valid drops.

## Structure
- Package `cpu_arb_pkg`: state encoding constants (`ARB_IDLE`, `ARB_GRANT`) and an idxW helper function.
- Sub-module `cpu_rr_picker`: combinational round-robin priority picker taking the `req_valid` vector and `last`, returning the pick index and an any-valid flag. Instantiated once.

## Test plan
- Reset, all `req_valid=0` → `req_full=4'b1111`, `output_valid=0`, `grant_active=0` for 10 cycles.
- Only producer 2 valid, data 0x10..0x13, `output_full=0` → grant 2 one cycle after valid. Output shows 0x10,0x11,0x12,0x13 on consecutive cycles.
- All four valid continuously, burst disabled → `grant_id` sequence 0,1,2,3,0,…, one beat per cycle, no bubble. With `CPU_ARB_BURST_EN` and `burst=4` → four beats from each producer before rotating.
- `output_full=1` for 3 cycles while holding beat 0xAA → `output_data` stays 0xAA, granted `req_full=1`, no beat lost or duplicated after release.
- Granted producer drops valid mid-burst while producer 3 is valid → grant moves to 3 at that edge.
- Assert reset while `output_valid=1` → next cycle `output_valid=0`, state IDLE, next grant goes to index 0 first.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the CPU FIFO write-port arbiter: FSM encoding and
// the grant-index width helper.
package cpu_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // A single producer still needs a one-bit index to drive grant_id.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_rr_picker.sv
// Combinational round-robin picker: lowest valid index at or after last+1,
// wrapping so that last itself has the lowest priority.
module cpu_rr_picker
  import cpu_arb_pkg::*;
#(
  parameter int requesters = 4,
  parameter int iw         = idx_w(requesters)
) (
  input  logic [requesters-1:0] valid,
  input  logic [iw-1:0]         last,
  output logic [iw-1:0]         pick,
  output logic                  any
);

  // Scan from the farthest candidate inwards so the nearest one wins.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = requesters; k >= 1; k--) begin
      int j;
      j = int'(last) + k;
      if (j >= requesters) j = j - requesters;
      if (valid[iw'(j)]) begin
        pick = iw'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_fifo_arbiter.sv
// Round-robin arbiter sharing one CPU FIFO write port among several producers.
// Define CPU_ARB_BURST_EN to let a grant carry up to `burst` beats.
module cpu_fifo_arbiter
  import cpu_arb_pkg::*;
#(
  parameter  int width      = 32,
  parameter  int requesters = 4,
  parameter  int burst      = 4,
  localparam int idx_width  = idx_w(requesters)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [requesters*width-1:0]  req_data,
  input  logic [requesters-1:0]        req_valid,
  output logic [requesters-1:0]        req_full,
  output logic [width-1:0]             output_data,
  output logic                         output_valid,
  input  logic                         output_full,
  output logic [idx_width-1:0]         grant_id,
  output logic                         grant_active
);

`ifdef CPU_ARB_BURST_EN
  localparam int beat_limit = burst;
`else
  localparam int beat_limit = 1;
`endif
  localparam int cnt_width = $clog2(burst + 1);

  arb_state_t           state;
  logic [idx_width-1:0] last;
  logic [cnt_width-1:0] beat_cnt;
  logic [idx_width-1:0] pick;
  logic                 pick_any;
  logic                 slot_free;
  logic                 granted_valid;
  logic                 accept;
  logic                 limit_hit;
  logic                 release_grant;

  cpu_rr_picker #(
    .requesters (requesters),
    .iw         (idx_width)
  ) u_picker (
    .valid (req_valid),
    .last  (last),
    .pick  (pick),
    .any   (pick_any)
  );

  assign slot_free     = !output_valid || !output_full;
  assign granted_valid = req_valid[grant_id];
  assign accept        = (state == ARB_GRANT) && granted_valid && slot_free;
  assign limit_hit     = accept && (beat_cnt == cnt_width'(beat_limit - 1));
  assign release_grant = (state == ARB_GRANT) &&
                         ((!granted_valid && slot_free) || limit_hit);

  // Backpressure depends only on grant state and the output slot, never on req_valid.
  always_comb begin
    req_full = '1;
    if ((state == ARB_GRANT) && slot_free) req_full[grant_id] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant_active <= 1'b0;
      grant_id     <= '0;
      last         <= idx_width'(requesters - 1);
      beat_cnt     <= '0;
      output_valid <= 1'b0;
      output_data  <= '0;
    end else begin
      if (accept) begin
        output_data  <= req_data[int'(grant_id)*width +: width];
        output_valid <= 1'b1;
      end else if (output_valid && !output_full) begin
        output_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state        <= ARB_GRANT;
            grant_active <= 1'b1;
            grant_id     <= pick;
            last         <= pick;
            beat_cnt     <= '0;
          end
        end
        ARB_GRANT: begin
          if (release_grant) begin
            beat_cnt <= '0;
            if (pick_any) begin
              grant_id <= pick;
              last     <= pick;
            end else begin
              state        <= ARB_IDLE;
              grant_active <= 1'b0;
            end
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fifo_arbiter.sv
// Scoreboard bench for cpu_fifo_arbiter: producers modelled as beat queues,
// expected beats queued at stimulus time and checked as the FIFO takes them.
module tb_cpu_fifo_arbiter;

  localparam int W   = 32;
  localparam int REQ = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [REQ*W-1:0] req_data;
  logic [REQ-1:0]   req_valid;
  logic [REQ-1:0]   req_full;
  logic [W-1:0]     output_data;
  logic             output_valid;
  logic             output_full;
  logic [1:0]       grant_id;
  logic             grant_active;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]   pq [REQ][$];
  logic [W-1:0]   sb [$];
  logic [REQ-1:0] en;
  logic [REQ-1:0] acc;
  logic           full_plan;

  cpu_fifo_arbiter #(.width(W), .requesters(REQ), .burst(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_full     (req_full),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_full  (output_full),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_gnt(input int k);
`ifdef CPU_ARB_BURST_EN
    return (k < 16) ? k / 4 : k - 16;
`else
    return k % 4;
`endif
  endfunction

  function automatic int exp_beat(input int k);
`ifdef CPU_ARB_BURST_EN
    return (k < 16) ? k % 4 : 4;
`else
    return k / 4;
`endif
  endfunction

  function automatic int acc_idx(input logic [REQ-1:0] a);
    int r;
    r = -1;
    for (int i = 0; i < REQ; i++) if (a[i]) r = i;
    return r;
  endfunction

  // One cycle of producer behaviour: retire last cycle's accepted beats,
  // present queue heads, then record which producers are being accepted.
  task automatic step();
    @(negedge clock);
    for (int i = 0; i < REQ; i++)
      if (acc[i] && !reset && pq[i].size() > 0) void'(pq[i].pop_front());
    for (int i = 0; i < REQ; i++) begin
      req_valid[i] = en[i] && (pq[i].size() > 0);
      req_data[i*W +: W] = req_valid[i] ? pq[i][0] : '0;
    end
    output_full = full_plan;
    #1;
    for (int i = 0; i < REQ; i++) acc[i] = req_valid[i] && !req_full[i];
  endtask

  task automatic do_reset();
    en        = '0;
    full_plan = 1'b0;
    for (int i = 0; i < REQ; i++) pq[i].delete();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every beat the FIFO takes must be the next expected one.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (output_valid && !output_full) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %0h, expected no beat", output_data);
        end else begin
          check("sb_beat", output_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    int bubbles;
    int exp_bubbles;
    bit started;

    req_data    = '0;
    req_valid   = '0;
    output_full = 1'b0;
    en          = '0;
    acc         = '0;
    full_plan   = 1'b0;

    // Reset and idle
    repeat (3) step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_req_full", req_full, 4'b1111);
      check("idle_out_valid", output_valid, 1'b0);
      check("idle_grant_active", grant_active, 1'b0);
    end

    // Single producer 2 streaming four beats
    do_reset();
    for (int b = 0; b < 4; b++) begin
      pq[2].push_back(32'h10 + b);
      sb.push_back(32'h10 + b);
    end
    en = 4'b0100;
    step();
    step();
    check("p2_grant_id", grant_id, 2);
    check("p2_grant_active", grant_active, 1'b1);
    check("p2_req_full", req_full, 4'b1011);
    for (int b = 0; b < 4; b++) begin
      step();
      check("p2_out_valid", output_valid, 1'b1);
      check("p2_out_data", output_data, 32'h10 + b);
    end
    step();
    check("p2_drained_valid", output_valid, 1'b0);
    check("p2_back_idle", grant_active, 1'b0);

    // All four producers continuously valid
    do_reset();
    for (int i = 0; i < REQ; i++)
      for (int b = 0; b < 5; b++) pq[i].push_back(32'hA000_0000 + i*16 + b);
    for (int j = 0; j < 20; j++)
      sb.push_back(32'hA000_0000 + exp_gnt(j)*16 + exp_beat(j));
    en = 4'b1111;
    k = 0;
    bubbles = 0;
    started = 1'b0;
    for (int s = 0; s < 60 && k < 20; s++) begin
      step();
      if ($countones(acc) == 1) begin
        check("rr_accept_idx", acc_idx(acc), exp_gnt(k));
        check("rr_grant_id", grant_id, exp_gnt(k));
        k++;
        started = 1'b1;
      end else if ($countones(acc) > 1) begin
        check("rr_onehot_accept", $countones(acc), 1);
      end else if (started) begin
        bubbles++;
      end
    end
`ifdef CPU_ARB_BURST_EN
    exp_bubbles = 3;
`else
    exp_bubbles = 0;
`endif
    check("rr_beats", k, 20);
    check("rr_bubbles", bubbles, exp_bubbles);
    repeat (4) step();

    // Downstream full while holding 0xAA
    do_reset();
    pq[1].push_back(32'hAA);
    pq[1].push_back(32'hBB);
    pq[1].push_back(32'hCC);
    sb.push_back(32'hAA);
    sb.push_back(32'hBB);
    sb.push_back(32'hCC);
    en = 4'b0010;
    step();
    step();
    check("full_first_accept", acc, 4'b0010);
    full_plan = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("full_hold_data", output_data, 32'hAA);
      check("full_hold_valid", output_valid, 1'b1);
      check("full_req_full", req_full, 4'b1111);
    end
    full_plan = 1'b0;
    repeat (6) step();
    check("full_p1_drained", pq[1].size(), 0);

    // Granted producer drops valid while producer 3 waits
    do_reset();
    pq[0].push_back(32'h51);
    pq[0].push_back(32'h52);
    pq[0].push_back(32'h53);
    pq[3].push_back(32'h31);
    sb.push_back(32'h51);
    sb.push_back(32'h52);
    sb.push_back(32'h31);
    sb.push_back(32'h53);
    en = 4'b0001;
    step();
    step();
    check("drop_acc0_a", acc, 4'b0001);
    step();
    check("drop_acc0_b", acc, 4'b0001);
    en = 4'b1000;
    step();
    check("drop_no_accept", acc, 4'b0000);
    check("drop_still_g0", grant_id, 0);
    step();
    check("drop_grant_3", grant_id, 3);
    check("drop_grant_active", grant_active, 1'b1);
    check("drop_acc3", acc, 4'b1000);
    en = 4'b1001;
    repeat (6) step();
    check("drop_p0_drained", pq[0].size(), 0);

    // Reset while a beat sits in the output register
    do_reset();
    pq[2].push_back(32'h61);
    pq[2].push_back(32'h62);
    en = 4'b0100;
    step();
    step();
    check("rst_acc_61", acc, 4'b0100);
    full_plan = 1'b1;
    step();
    check("rst_held_valid", output_valid, 1'b1);
    reset = 1'b1;
    pq[0].push_back(32'h01);
    sb.push_back(32'h01);
    sb.push_back(32'h62);
    en = 4'b0101;
    full_plan = 1'b0;
    step();
    check("rst_out_valid", output_valid, 1'b0);
    check("rst_out_data", output_data, 32'h0);
    check("rst_grant_active", grant_active, 1'b0);
    check("rst_req_full", req_full, 4'b1111);
    reset = 1'b0;
    step();
    check("rst_first_grant", grant_id, 0);
    check("rst_first_acc", acc, 4'b0001);
    repeat (6) step();

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
